uart_rx_oversampled: RTL and testbench

UART receive stage sitting directly upstream of the transmit/echo controller. It produces the byte stream that the controller consumes.
- Deserialises 8N1 frames from the asynchronous Rx line using 16x oversampling with a 3-sample majority vote per bit.
- Delivers each good byte with a one-cycle strobe.
- Flags framing errors and recovers cleanly from line breaks.

---
 rtl/uart_rx_oversampled.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver with 16x oversampling and a 3-sample majority vote
// per bit. It feeds the byte stream consumed by the transmit/echo controller.
//
// Optional build macro UART_RX_PARITY_EN adds a parity bit between the data bits and the
// stop bit, the PARITY_ODD parameter and the parity_error_o output.
//
// Ports:
//   CLK_i           system clock, all logic on its rising edge
//   Reset_i         synchronous, active-high reset
//   Rx_i            asynchronous serial input, idle high
//   data_o          last correctly received byte
//   data_ready_o    one-cycle pulse, data_o valid on the same cycle
//   frame_error_o   one-cycle pulse when the stop bit is sampled low
//   parity_error_o  (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
//   busy_o          high from start-edge detection until the return to idle
module uart_rx_oversampled #(
  parameter int unsigned FREQUENCY  = 32'd50_000_000,
  parameter int unsigned SPEED      = 32'd9600,
  // Fixed at 16; the bit-phase logic below assumes a 4-bit oversample counter.
  parameter int unsigned OVERSAMPLE = 16,
`ifdef UART_RX_PARITY_EN
  parameter bit          PARITY_ODD = 1'b0,
`endif
  parameter int unsigned TICK_DIV   = FREQUENCY / (SPEED * OVERSAMPLE)
) (
  input  logic       CLK_i,
  input  logic       Reset_i,
  input  logic       Rx_i,
  output logic [7:0] data_o,
  output logic       data_ready_o,
  output logic       frame_error_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error_o,
`endif
  output logic       busy_o
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e state_q, state_d;

  // Input synchroniser and edge detector
  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic fall;

  // Timing
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             tick, decide, wrap;

  // Majority vote
  logic [1:0] samp_q, samp_d;
  logic       vote;

  // Data path
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       data_ready_q, frame_error_q;
  logic       ready_set, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic       parity_bad_q, parity_bad_d;
  logic       parity_error_q;
  logic       perr_set;
`endif

  assign fall = rx_prev_q & ~rx_s_q;

  // Tick counter only runs outside idle, so it starts from zero on the start edge.
  assign tick = (state_q != StIdle) && (tick_cnt_q == TickLast);

  // os_cnt counts ticks elapsed in the current bit. The vote samples are taken on the
  // ticks that bring it to 7 and 8, and the decision on the tick that brings it to 9.
  assign decide = tick && (os_cnt_q == 4'd8);
  assign wrap   = tick && (os_cnt_q == 4'd15);

  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  // ---------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge CLK_i) begin
    if (Reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StStart;
      end
      StStart: begin
        // A high vote means the start edge was a glitch.
        if (decide && vote)  state_d = StIdle;
        else if (wrap)       state_d = StData;
      end
      StData: begin
        if (wrap && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (wrap) state_d = StStop;
      end
`endif
      StStop: begin
        // Leave at the decision; the rest of the stop bit is absorbed by idle.
        if (decide) state_d = vote ? StIdle : StBreak;
      end
      StBreak: begin
        if (tick && rx_s_q && (os_cnt_q == 4'd15)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------
  always_comb begin
    busy_o    = (state_q != StIdle);
    ready_set = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    if ((state_q == StStop) && decide) begin
      if (!vote) begin
        ferr_set = 1'b1;
      end else begin
`ifdef UART_RX_PARITY_EN
        perr_set  = parity_bad_q;
        ready_set = ~parity_bad_q;
`else
        ready_set = 1'b1;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Counters, vote samples and data path next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    data_d     = data_q;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif

    if (state_q == StIdle) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    // Every state change happens either at a bit wrap or where the phase must restart.
    if (state_d != state_q) begin
      os_cnt_d = 4'd0;
    end else if (state_q == StBreak) begin
      // Counts consecutive high ticks; any low sample restarts the count.
      if (!rx_s_q)   os_cnt_d = 4'd0;
      else if (tick) os_cnt_d = os_cnt_q + 4'd1;
    end else if (tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
    end

    if (state_q != StData) begin
      bit_idx_d = 3'd0;
    end else if (wrap) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end

    if (tick && (os_cnt_q == 4'd6)) samp_d[0] = rx_s_q;
    if (tick && (os_cnt_q == 4'd7)) samp_d[1] = rx_s_q;

    // LSB first: each new bit enters at the top and shifts down.
    if ((state_q == StData) && decide) shift_d = {vote, shift_q[7:1]};

`ifdef UART_RX_PARITY_EN
    if (state_q == StIdle) begin
      parity_bad_d = 1'b0;
    end else if ((state_q == StParity) && decide) begin
      parity_bad_d = ((^shift_q) ^ vote) != PARITY_ODD;
    end
`endif

    if (ready_set) data_d = shift_q;
  end

  always_ff @(posedge CLK_i) begin
    if (Reset_i) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      tick_cnt_q    <= '0;
      os_cnt_q      <= 4'd0;
      bit_idx_q     <= 3'd0;
      samp_q        <= 2'b00;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= Rx_i;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      tick_cnt_q    <= tick_cnt_d;
      os_cnt_q      <= os_cnt_d;
      bit_idx_q     <= bit_idx_d;
      samp_q        <= samp_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_ready_q  <= ready_set;
      frame_error_q <= ferr_set;
`ifdef UART_RX_PARITY_EN
      parity_bad_q   <= parity_bad_d;
      parity_error_q <= perr_set;
`endif
    end
  end

  assign data_o        = data_q;
  assign data_ready_o  = data_ready_q;
  assign frame_error_o = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error_o = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled. Runs at a reduced baud divider
// (8 clocks per oversample tick) so full frames stay short.
module tb_uart_rx_oversampled;

  localparam int unsigned FREQ  = 50_000_000;
  localparam int unsigned BAUD  = 390_625;
  localparam int          TD    = 8;          // 50e6 / (390625 * 16)
  localparam int          BIT   = 16 * TD;
  localparam int          SPIKE_LEN = 5;      // hits exactly one vote sample
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_ODD = 1'b0;
  localparam int          NBITS   = 11;
`else
  localparam int          NBITS   = 10;
`endif

  localparam int KData = 0;
  localparam int KFerr = 1;
  localparam int KPerr = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       ready, ferr, busy, perr;

  uart_rx_oversampled #(
    .FREQUENCY (FREQ),
    .SPEED     (BAUD)
  ) dut (
    .CLK_i         (clk),
    .Reset_i       (rst),
    .Rx_i          (rx),
    .data_o        (data),
    .data_ready_o  (ready),
    .frame_error_o (ferr),
`ifdef UART_RX_PARITY_EN
    .parity_error_o(perr),
`endif
    .busy_o        (busy)
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         sbit;     // frame bit index carrying a spike, -1 for none
    int         stick;    // vote tick (7, 8 or 9) the spike lands on
    int         gap;      // idle bits before the frame
    logic       chk_gap;  // check busy low time before this back-to-back frame
    int         kind;
    logic [7:0] exp;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cyc = 0;
  int   last_evt_cyc = 0;
  logic mon_en = 1'b0;
  logic gap_win = 1'b0;
  logic busy_prev = 1'b0;
  int   low_run = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard and busy-gap monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) begin
        low_run++;
      end else begin
        if (!busy_prev && gap_win) begin
          n_cmp++;
          if (low_run > 8 * TD) begin
            n_err++;
            $display("FAIL busy_gap: got %0d cycles low, required <= %0d", low_run, 8 * TD);
          end
        end
        low_run = 0;
      end
      busy_prev = busy;

      if (ready || ferr || perr) begin
        int   got_kind;
        exp_t e;
        got_kind = ferr ? KFerr : (perr ? KPerr : KData);
        last_evt_cyc = cyc;
        if (int'(ready) + int'(ferr) + int'(perr) > 1) begin
          n_cmp++;
          n_err++;
          $display("FAIL strobe_excl: ready=%0b ferr=%0b perr=%0b", ready, ferr, perr);
        end else if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: kind %0d data %0h, none required", got_kind, data);
        end else begin
          e = q.pop_front();
          check("strobe_kind_data", {got_kind[23:0], data}, {e.kind[23:0], e.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) step();
  endtask

  // Drives one frame cycle by cycle; optionally inverts the line around one vote sample
  // and stops after max_cyc cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_cyc,
                            input logic par_flip, input int max_cyc);
    logic bits [0:10];
    int   n;
    logic v;
    for (int i = 0; i < 11; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
    n = 9;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ PAR_ODD ^ par_flip;
    n = 10;
`else
    if (par_flip) n = 9;
`endif
    bits[n] = stop;
    n++;
    start_cyc = cyc;
    for (int c = 0; c < n * BIT; c++) begin
      if (max_cyc >= 0 && c >= max_cyc) break;
      v = bits[c / BIT];
      if (spike_cyc >= 0 && c >= spike_cyc && c < spike_cyc + SPIKE_LEN) v = ~v;
      rx = v;
      step();
    end
  endtask

  vec_t vecs [0:8];

  initial begin
    int   lat;
    int   lat_exp;
    int   sc;
    logic saw_busy;

    vecs[0] = '{8'h00, 1'b1, -1, 0, 2, 1'b0, KData, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, -1, 0, 0, 1'b1, KData, 8'hFF};
    vecs[2] = '{8'h55, 1'b1, -1, 0, 0, 1'b1, KData, 8'h55};
    vecs[3] = '{8'h3C, 1'b0, -1, 0, 2, 1'b0, KFerr, 8'h55};
    vecs[4] = '{8'h81, 1'b1, -1, 0, 2, 1'b0, KData, 8'h81};
    vecs[5] = '{8'h00, 1'b1,  4, 8, 2, 1'b0, KData, 8'h00};
    vecs[6] = '{8'hFF, 1'b1,  6, 7, 2, 1'b0, KData, 8'hFF};
    vecs[7] = '{8'h5A, 1'b1,  1, 9, 2, 1'b0, KData, 8'h5A};
    vecs[8] = '{8'h96, 1'b1,  0, 8, 2, 1'b0, KData, 8'h96};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) step();
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (8) step();

    // First frame: strobe latency from the line falling edge.
    q.push_back('{KData, 8'hA5});
    send_frame(8'hA5, 1'b1, -1, 1'b0, -1);
    lat = last_evt_cyc - start_cyc;
    lat_exp = 2 + (9 * 16 + 9) * TD + 1 + (NBITS - 10) * 16 * TD;
    n_cmp++;
    if (lat < lat_exp - 2 || lat > lat_exp + 2) begin
      n_err++;
      $display("FAIL latency: got %0d cycles, required %0d +/- 2", lat, lat_exp);
    end

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].gap > 0) idle_bits(vecs[i].gap);
      gap_win = vecs[i].chk_gap;
      q.push_back('{vecs[i].kind, vecs[i].exp});
      sc = (vecs[i].sbit < 0) ? -1 : (16 * vecs[i].sbit + vecs[i].stick) * TD - 2;
      send_frame(vecs[i].data, vecs[i].stop, sc, 1'b0, -1);
      if (!vecs[i].stop) begin
        rx = 1'b0;
        repeat (20 * BIT) step();
        rx = 1'b1;
      end
    end
    gap_win = 1'b0;

    // Low pulse that ends before the first vote sample: rejected in START.
    idle_bits(2);
    rx = 1'b0;
    repeat (40) step();
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int c = 0; c < 3 * BIT; c++) begin
      if (busy) saw_busy = 1'b1;
      step();
    end
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_data_kept", {24'd0, data}, 32'h96);

    // Reset in the middle of data bit 4; the transmitter is reset too, so the line idles.
    idle_bits(2);
    send_frame(8'hC3, 1'b1, -1, 1'b0, (16 * 5 + 8) * TD);
    rst = 1'b1;
    rx  = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    idle_bits(12);
    q.push_back('{KData, 8'h7E});
    send_frame(8'h7E, 1'b1, -1, 1'b0, -1);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    q.push_back('{KData, 8'h07});
    send_frame(8'h07, 1'b1, -1, 1'b0, -1);
    idle_bits(2);
    q.push_back('{KPerr, 8'h07});
    send_frame(8'h07, 1'b1, -1, 1'b1, -1);
    idle_bits(2);
`endif

    idle_bits(2);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
